toggle_decoder: RTL and testbench

- Receive-side counterpart of the T flip-flop: recovers discrete events from a toggle-encoded level.
- Each transition on `tog_in` produces a one-cycle `evt_pulse` and increments an event counter.
- The cycle count between consecutive transitions is offered on a valid/ready interface.
- Sits downstream of any T-FF-encoded event source, e.g. as a rate monitor.

---
 rtl/toggle_decoder_pkg.sv | 11 +
 rtl/toggle_edge_det.sv | 33 +++
 rtl/toggle_decoder.sv | 89 ++++++++
 tb/tb_toggle_decoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/toggle_decoder_pkg.sv
// toggle_decoder_pkg: state encoding and default parameters shared by the toggle decoder.
package toggle_decoder_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    STALLED = 2'd2
  } tdec_state_t;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_INT_W   = 16;
  localparam int DEF_TIMEOUT = 1000;
endpackage

// File: rtl/toggle_edge_det.sv
// toggle_edge_det: turns level transitions on tog_in into a single-cycle evt strobe.
// TOGGLE_DECODER_SYNC_EN adds a 2-flop synchronizer in front of the edge detector.
module toggle_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic tog_in,
  output logic evt
);
  logic tog_s;
  logic tog_q;
  logic primed_q;
`ifdef TOGGLE_DECODER_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], tog_in};
  end
  assign tog_s = sync_q[1];
`else
  assign tog_s = tog_in;
`endif
  // The first sample after reset only seeds tog_q, so a static level is never mistaken for an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog_q    <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      tog_q    <= tog_s;
      primed_q <= 1'b1;
    end
  end
  assign evt = primed_q & (tog_s ^ tog_q);
endmodule

// File: rtl/toggle_decoder.sv
// toggle_decoder: recovers events from a toggle-encoded level, counts them and reports inter-event intervals.
// Define TOGGLE_DECODER_SYNC_EN to synchronize tog_in (adds 2 cycles of event latency).
module toggle_decoder
  import toggle_decoder_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int INT_W   = DEF_INT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  input  logic             clr,
  output logic             evt_pulse,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             int_valid,
  input  logic             int_ready,
  output logic [INT_W-1:0] int_data,
  output logic             ovf,
  output logic             stalled,
  output logic [1:0]       state
);
  localparam logic [INT_W-1:0] TO = INT_W'(TIMEOUT);
  logic             evt;
  tdec_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [INT_W-1:0] icnt_q, icnt_d;
  logic [INT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             pulse_q, stalled_q;
  logic             push, xfer, load;

  toggle_edge_det u_edge (
    .clk   (clk),
    .rst   (rst),
    .tog_in(tog_in),
    .evt   (evt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The first event after IDLE only starts timing; later events emit the elapsed interval.
  always_comb begin
    push    = evt & ~clr & (state_q != IDLE);
    xfer    = valid_q & int_ready;
    load    = push & (~valid_q | xfer);
    icnt_d  = clr ? '0 : evt ? INT_W'(1) : (&icnt_q) ? icnt_q : icnt_q + 1'b1;
    cnt_d   = clr ? '0 : evt ? cnt_q + 1'b1 : cnt_q;
    valid_d = clr ? 1'b0 : load ? 1'b1 : xfer ? 1'b0 : valid_q;
    data_d  = load ? icnt_q : data_q;
    ovf_d   = clr ? 1'b0 : (push & ~load) ? 1'b1 : ovf_q;
    state_d = state_q;
    if (clr)                     state_d = IDLE;
    else if (evt)                state_d = ACTIVE;
    else if (state_q == ACTIVE && icnt_d == TO) state_d = STALLED;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      icnt_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      pulse_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      icnt_q    <= icnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      pulse_q   <= evt & ~clr;
      stalled_q <= (state_d == STALLED);
    end
  end

  assign evt_pulse = pulse_q;
  assign evt_cnt   = cnt_q;
  assign int_valid = valid_q;
  assign int_data  = data_q;
  assign ovf       = ovf_q;
  assign stalled   = stalled_q;
  assign state     = state_q;
endmodule

// File: tb/tb_toggle_decoder.sv
// tb_toggle_decoder: directed stimulus with a queue-based scoreboard for interval transfers.
module tb_toggle_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tog_in = 1'b1;
  logic        clr = 1'b0;
  logic        int_ready = 1'b1;
  logic        evt_pulse, int_valid, ovf, stalled;
  logic [1:0]  evt_cnt;
  logic [15:0] int_data;
  logic [1:0]  state;
  int          checks = 0;
  int          errors = 0;
  int          exp_q[$];
  int          wrap_exp[5] = '{1, 2, 3, 0, 1};
  logic        saw_pulse;

  toggle_decoder #(.CNT_W(2), .INT_W(16), .TIMEOUT(20)) dut (
    .clk      (clk),
    .rst      (rst),
    .tog_in   (tog_in),
    .clr      (clr),
    .evt_pulse(evt_pulse),
    .evt_cnt  (evt_cnt),
    .int_valid(int_valid),
    .int_ready(int_ready),
    .int_data (int_data),
    .ovf      (ovf),
    .stalled  (stalled),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic toggle();
    tog_in = ~tog_in;
    tick(1);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (int_valid && int_ready) begin
          if (exp_q.size() == 0) chk("unexpected_transfer", int'(int_data), -1);
          else chk("sb_int_data", int'(int_data), exp_q.pop_front());
        end
      end
    join_none
    // reset seed: input held high through and after reset
    tick(3);
    chk("rst_evt_cnt", int'(evt_cnt), 0);
    rst = 1'b0;
    saw_pulse = 1'b0;
    repeat (10) begin
      tick(1);
      saw_pulse = saw_pulse | evt_pulse;
    end
    chk("seed_no_pulse", int'(saw_pulse), 0);
    chk("seed_evt_cnt", int'(evt_cnt), 0);
    chk("seed_state", int'(state), 0);
    chk("seed_valid", int'(int_valid), 0);
    chk("seed_int_data", int'(int_data), 0);
    chk("seed_ovf", int'(ovf), 0);
    chk("seed_stalled", int'(stalled), 0);
    // three toggles 4 cycles apart
    toggle();
    chk("t1_pulse", int'(evt_pulse), 1);
    chk("t1_cnt", int'(evt_cnt), 1);
    chk("t1_no_interval", int'(int_valid), 0);
    chk("t1_state", int'(state), 1);
    tick(1);
    chk("t1_pulse_one_cycle", int'(evt_pulse), 0);
    tick(2);
    exp_q.push_back(4);
    toggle();
    chk("t2_cnt", int'(evt_cnt), 2);
    chk("t2_valid", int'(int_valid), 1);
    tick(3);
    exp_q.push_back(4);
    toggle();
    chk("t3_cnt", int'(evt_cnt), 3);
    chk("t3_state", int'(state), 1);
    tick(1);
    chk("t3_valid_drop", int'(int_valid), 0);
    // overflow: held word survives a dropped interval
    int_ready = 1'b0;
    tick(1);
    exp_q.push_back(3);
    toggle();
    chk("ovf_first_data", int'(int_data), 3);
    chk("ovf_not_yet", int'(ovf), 0);
    tick(4);
    toggle();
    chk("ovf_hold_data", int'(int_data), 3);
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_valid", int'(int_valid), 1);
    chk("ovf_cnt_wrap", int'(evt_cnt), 1);
    int_ready = 1'b1;
    tick(1);
    chk("ovf_valid_fall", int'(int_valid), 0);
    chk("ovf_sticky", int'(ovf), 1);
    // clear with a pending interval, then clear swallowing a transition
    int_ready = 1'b0;
    toggle();
    chk("clr_pending", int'(int_valid), 1);
    clr = 1'b1;
    tick(1);
    chk("clr_valid", int'(int_valid), 0);
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_cnt", int'(evt_cnt), 0);
    chk("clr_state", int'(state), 0);
    tog_in = ~tog_in;
    tick(1);
    clr = 1'b0;
    chk("clr_lost_pulse", int'(evt_pulse), 0);
    tick(1);
    chk("clr_lost_late", int'(evt_pulse), 0);
    chk("clr_lost_cnt", int'(evt_cnt), 0);
    // counter wrap with CNT_W=2
    int_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) exp_q.push_back(2);
      toggle();
      chk("wrap_cnt", int'(evt_cnt), wrap_exp[i]);
      tick(1);
    end
    // timeout at 20 cycles, recovery after 26
    exp_q.push_back(2);
    toggle();
    tick(18);
    chk("pre_stall", int'(stalled), 0);
    chk("pre_stall_state", int'(state), 1);
    tick(1);
    chk("stalled", int'(stalled), 1);
    chk("stall_state", int'(state), 2);
    tick(6);
    exp_q.push_back(26);
    toggle();
    chk("unstall", int'(stalled), 0);
    chk("unstall_state", int'(state), 1);
    chk("unstall_data", int'(int_data), 26);
    // asynchronous reset mid-cycle with a pending interval
    tick(3);
    int_ready = 1'b0;
    toggle();
    chk("arst_pending", int'(int_valid), 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_pulse", int'(evt_pulse), 0);
    chk("arst_cnt", int'(evt_cnt), 0);
    chk("arst_valid", int'(int_valid), 0);
    chk("arst_data", int'(int_data), 0);
    chk("arst_ovf", int'(ovf), 0);
    chk("arst_stalled", int'(stalled), 0);
    chk("arst_state", int'(state), 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
